// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing for the run-time programmable LUT neuron.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int IN_BITS_DEF  = 6;
  localparam int OUT_BITS_DEF = 2;

  function automatic int depth(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// Flop-based truth table: one write port, one registered read port, async clear.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = depth(IN_BITS);

  logic [DEPTH-1:0][OUT_BITS-1:0] mem;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  mem <= '0;
    else if (we) mem[waddr] <= wdata;

  // Read data holds between reads so the output keeps its last value.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/lut_neuron_loader.sv
// Loadable LogicNet neuron: streams a truth table in, then evaluates activations.
// Optional LUT_NEURON_PARITY_EN adds even-parity checking on config beats.
module lut_neuron_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                load_done,
  output logic                table_ok,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
`ifdef LUT_NEURON_PARITY_EN
  ,
  input  logic                cfg_parity,
  output logic                cfg_err
`endif
);

  localparam int                 DEPTH  = depth(IN_BITS);
  localparam logic [IN_BITS-1:0] LAST   = IN_BITS'(DEPTH - 1);
  localparam int                 STAGES = 1;

  state_t             state, state_nx;
  logic [IN_BITS-1:0] wr_addr, wr_addr_nx;
  logic               done_nx, we, re;
  logic [STAGES:1]    vld_q;
  wire  [STAGES:0]    vld_pipe;

`ifdef LUT_NEURON_PARITY_EN
  logic err_q, err_nx, par_bad;
  assign par_bad = cfg_parity != ^cfg_data;
  assign cfg_err = err_q;
`endif

  always_comb begin
    state_nx   = state;
    wr_addr_nx = wr_addr;
    done_nx    = 1'b0;
    we         = 1'b0;
`ifdef LUT_NEURON_PARITY_EN
    err_nx     = err_q;
`endif
    // A restart beats any beat arriving in the same cycle.
    if (cfg_start) begin
      state_nx   = LOAD;
      wr_addr_nx = '0;
`ifdef LUT_NEURON_PARITY_EN
      err_nx     = 1'b0;
`endif
    end else if (state == LOAD && cfg_valid) begin
      we         = 1'b1;
      wr_addr_nx = wr_addr + 1'b1;
`ifdef LUT_NEURON_PARITY_EN
      err_nx     = err_q | par_bad;
`endif
      if (wr_addr == LAST) begin
        done_nx    = 1'b1;
        wr_addr_nx = '0;
`ifdef LUT_NEURON_PARITY_EN
        state_nx   = (err_q | par_bad) ? IDLE : RUN;
`else
        state_nx   = RUN;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      wr_addr   <= '0;
      load_done <= 1'b0;
      vld_q     <= '0;
`ifdef LUT_NEURON_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      wr_addr   <= wr_addr_nx;
      load_done <= done_nx;
      vld_q     <= vld_pipe[STAGES-1:0];
`ifdef LUT_NEURON_PARITY_EN
      err_q     <= err_nx;
`endif
    end

  assign re        = (state == RUN) && in_valid;
  assign vld_pipe  = {vld_q, re};
  assign cfg_ready = (state == LOAD);
  assign table_ok  = (state == RUN);
  assign out_valid = vld_pipe[STAGES];

  lut_neuron_table #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_addr),
    .wdata (cfg_data),
    .re    (re),
    .raddr (in_data),
    .rdata (out_data)
  );

endmodule

// File: doc/lut_neuron_loader.md
# lut_neuron_loader

Run-time programmable 6-input / 2-output LogicNet neuron, the writer side of the fixed truth-table ROM neurons. It accepts a streamed 64-entry truth table over a valid/ready configuration port and stores it in a flop-based table. It then evaluates quantised activations against that table with a one-cycle registered output. It sits between the host configuration bus and a layer slot. Trained tables can therefore be swapped without re-synthesis.

## Interface
- `IN_BITS`, 6, neuron input width (fan-in × activation bits); table depth `DEPTH = 2**IN_BITS`.
- `OUT_BITS`, 2, neuron output width (one entry width).
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle pulse; begins or restarts a table load.
- `cfg_valid`  in  1  a configuration beat is present.
- `cfg_data`  in  OUT_BITS  table entry for the current address.
- `cfg_ready`  out  OUT_BITS→1  high only in LOAD.
- `load_done`  out  1  one-cycle pulse when the last entry is written.
- `table_ok`  out  1  high while a complete table is held (RUN).
- `in_valid`  in  1  activation present.
- `in_data`  in  IN_BITS  activation vector, used as the table address.
- `out_valid`  out  1  registered result valid.
- `out_data`  out  OUT_BITS  registered `table[in_data]`.

## Operation
- **States:** IDLE, LOAD, RUN. Reset state is IDLE.
- **IDLE → LOAD:** on `cfg_start`.
- **LOAD:**
  - `cfg_ready` = 1.
  - Each `cfg_valid && cfg_ready` writes `table[wr_addr] <= cfg_data` and increments the `IN_BITS`-wide `wr_addr`.
  - Stream order: beat k is the output for `in_data == k`, where `in_data[0]` is the LSB of k.
  - The beat with `wr_addr == DEPTH-1` moves the FSM to RUN, pulses `load_done` and clears `wr_addr` to 0.
- **RUN:** each `in_valid` registers `out_data <= table[in_data]` and `out_valid <= 1`; otherwise `out_valid <= 0`. `out_data` holds its last value.
- **`cfg_start` in any state:**
  - Goes to LOAD, clears `wr_addr` and drops `table_ok`.
  - Old table contents remain but are unusable until the reload completes.
- **Simultaneous `cfg_start` and `cfg_valid` in LOAD:** start wins, the beat is discarded, and `wr_addr` = 0.
- **`in_valid` outside RUN:** ignored; `out_valid` stays 0. This includes the cycle of the final config beat.
- **`in_valid` in the cycle `cfg_start` is seen in RUN:** still evaluated against the old table, because the state is RUN for that cycle.
- **No output backpressure:** the consumer must accept every `out_valid` pulse.

## Timing
- Reset values: `cfg_ready` 0, `load_done` 0, `table_ok` 0, `out_valid` 0, `out_data` 0, all table entries 0, `wr_addr` 0.
- `cfg_ready` rises in the cycle after the `cfg_start` edge.
- A full load takes `DEPTH` accepted beats, minimum 64 cycles. `load_done` and `table_ok` assert in the cycle after the last beat.
- Evaluation latency is 1 cycle (`in_valid` at edge n gives `out_valid` after edge n). Throughput is 1 per cycle.
- Reset asserted mid-load or mid-run: immediate return to IDLE with all reset values; no partial table is flagged as valid.

## Configuration
- `LUT_NEURON_PARITY_EN`:
  - **Defined:** adds input `cfg_parity` (even parity over `cfg_data`) and output `cfg_err` (sticky; cleared by `cfg_start`).
    - A beat with a parity mismatch is still written, but sets `cfg_err`.
    - At the end of the load, `table_ok` stays 0 and the FSM returns to IDLE instead of RUN. `load_done` still pulses.
  - **Undefined:** no parity port, `cfg_err` is absent, and behaviour is exactly as above.

## Structure
- Package `lut_neuron_pkg`:
  - `state_t` enum (IDLE/LOAD/RUN).
  - Default `IN_BITS` and `OUT_BITS` constants.
  - `DEPTH` function.
- One sub-module: `lut_neuron_table`.
  - Write port (we, waddr, wdata).
  - Registered read port (re, raddr → rdata).
  - Asynchronous clear.
- The FSM, counter and handshake logic stay in the top level.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream → all outputs 0 next sample; `in_valid` with `in_data = 6'd5` gives no `out_valid`.
- **Load and evaluate:**
  - Load `table[k] = k[1:0] ^ k[5:4]`.
  - Then `in_data = 6'd37` → `out_data = 2'b11` one cycle later.
  - `in_data = 6'd0` → `2'b00`.
- **Backpressure on the config stream:** load with `cfg_valid` toggled every other cycle → `load_done` pulse after exactly 64 accepted beats; table correct.
- **Restart mid-load:**
  - Send `cfg_start` after beat 20, with `cfg_valid` high in the same cycle → that beat is dropped.
  - A full 64-beat reload then completes, and `table_ok` rises only afterwards.
- **Back-to-back evaluation:** 64 consecutive `in_valid` cycles covering addresses 0..63 → 64 consecutive `out_valid` pulses matching the loaded table.
- **Parity (macro defined):** corrupt parity on beat 10 → `cfg_err` = 1, `table_ok` stays 0 after `load_done`, and the FSM is in IDLE.
